ppwm_exec: RTL and testbench
============================

# ppwm_exec

Instruction decoder and executor for the programmable PWM. It fetches 8-bit command words from an external program store, executes one per cycle, and updates the PWM value register, the general register and the compare flag. It drives a free-running global period counter and the registered PWM output. It is the consuming end of the command encoding held in `ppwm_pkg`.

## Interface
- `PROG_DEPTH`, default 16: number of program slots; power of two; `pc_o` width is `$clog2(PROG_DEPTH)`.
- `clk_i`  in  1  clock.
- `rst_ni`  in  1  asynchronous active-low reset.
- `ena_i`  in  1  global enable; low freezes all state.
- `start_i`  in  1  single-cycle pulse that starts or restarts the program at slot 0.
- `instr_i`  in  8  command word at `pc_o`, combinational read, valid in the same cycle.
- `pc_o`  out  `$clog2(PROG_DEPTH)`  program counter.
- `pwm_o`  out  1  registered PWM output.
- `running_o`  out  1  high in RUN or WAIT.
- `err_o`  out  1  sticky reserved-command error (see Configuration).

## Operation
- **Word format:** `[7:5]` = command (`command_e`), `[4]` = target (`target_e`: PWM value or REG), `[3:0]` = argument `arg`.
- **Datapath:** 8-bit `pwm_val`, 8-bit `reg_val`, 1-bit `flag`, 8-bit `gcnt`.
- **States:** IDLE, RUN, WAIT, HALT.
  - `start_i` from any state → RUN, with `pc` = 0. Registers and `gcnt` are kept.
  - The RUN/WAIT/HALT transitions below are driven by commands.
- **CMD_CTRL** (`arg[1:0]`):
  - 00: NOP.
  - 01: HALT → HALT state; `pc` is held.
  - 10: WAIT → WAIT state, staying there until `gcnt` == 255. In that cycle: RUN, `pc`+1.
  - 11: RESTART → `pc` = 0.
- **CMD_SET:** target ← `{arg, 4'h0}`.
- **CMD_ARITH:** target ← target + sign-extended `arg` (range −8..+7). Saturates at 0 and 255.
- **CMD_SHIFT:** logical shift of the target, zero-filled.
  - `arg[3]` = 0 → left, `arg[3]` = 1 → right.
  - `arg[2:0]` = shift amount, 0..7.
- **CMD_RSRV:** NOP unless the macro in Configuration is defined.
- **CMD_JUMP:** `pc` ← `pc` + sign-extended `arg`, modulo `PROG_DEPTH`. The target bit is ignored.
- **CMD_CMP:**
  - `arg[1:0]` is a `cmp_args_e` selecting operands (a, b):
    - GCNT_PWM → (`gcnt`, `pwm_val`)
    - GCNT_REG → (`gcnt`, `reg_val`)
    - PWM_REG → (`pwm_val`, `reg_val`)
  - `arg[2]` = 0 → `flag` ← a < b (unsigned). `arg[2]` = 1 → `flag` ← a == b.
  - Selector 11 → `flag` ← 0.
- **CMD_BRANCH:** if `flag` is set, jump as for JUMP; otherwise `pc`+1. `flag` is unchanged.
- **`pc` advance:** every non-control-flow command in RUN advances `pc`+1, wrapping at `PROG_DEPTH`.
- **Global counter:** `gcnt` increments every cycle while `ena_i` is high, in all states, wrapping 255→0.
- **PWM output:** `pwm_o` ← (`gcnt` < `pwm_val`), registered. `pwm_val` = 0 gives constant low; 255 gives high for 255 of 256 cycles.

## Timing
- **Reset values:** `pc` = 0, `pwm_val` = 0, `reg_val` = 0, `flag` = 0, `gcnt` = 0, state IDLE, `pwm_o` = 0, `running_o` = 0, `err_o` = 0.
- **Execution rate:** one command per cycle in RUN. A command sampled at edge n updates its register and `pc` at edge n.
- **PWM latency:** a new `pwm_val` affects `pwm_o` from edge n+1.
- **`ena_i` low:** every register holds, including `gcnt` and `pwm_o`. `start_i` is ignored while `ena_i` is low.
- **`start_i` priority:** `start_i` overrides the command in the same cycle. That command's register update is discarded and `pc` ← 0.
- **WAIT entered at `gcnt` == 255:** the state moves to WAIT. It does not exit until the next 255, 256 cycles later.
- **Reset mid-operation:** all state returns to the reset values immediately, asynchronously.

## Configuration
- **`PPWM_RSRV_TRAP_EN` defined:**
  - CMD_RSRV sets `err_o` sticky and moves to HALT; `pc` is held.
  - `err_o` clears only on reset or `start_i`.
- **Not defined:** CMD_RSRV acts as NOP and `err_o` is tied to 0.

## Structure
- **`ppwm_pkg` additions:**
  - `exec_state_e` (IDLE/RUN/WAIT/HALT).
  - `ctrl_func_e` (NOP/HALT/WAIT/RESTART).
  - A packed `instr_t` struct (`cmd`, `trgt`, `arg`).
  - Constant `GCNT_MAX` = 8'hFF.
- **Sub-module `ppwm_alu`:** combinational; computes SET/ARITH/SHIFT results from the command, operand and `arg`. Saturation logic lives there.

## Test plan
- **Reset and enable:** reset, `ena_i` = 1, no start → `pwm_o` = 0, `pc_o` = 0, `running_o` = 0, while `gcnt` counts.
- **SET PWM and WAIT loop:** program SET PWM `arg` = 8, then WAIT, then JUMP −2 → `pwm_o` high for exactly 128 of every 256 cycles after the first period.
- **ARITH saturation:** SET REG `arg` = 0, then ARITH REG −1 → `reg_val` = 0. SET REG `arg` = 15, ARITH REG +7, three times → `reg_val` = 255.
- **SHIFT and CMP/BRANCH:**
  - SET PWM `arg` = 1 (16), SHIFT PWM right 4 → `pwm_val` = 1.
  - CMP PWM_REG eq with `reg_val` = 1 → `flag` = 1; a following BRANCH +3 → `pc` advances by 3.
- **JUMP wrap and start override:**
  - JUMP −1 at `pc` = 0 → `pc` = 15.
  - `start_i` asserted during an ARITH cycle → `pc` = 0 and the register is unchanged.
- **Reserved command:** CMD_RSRV with `PPWM_RSRV_TRAP_EN` → `err_o` = 1 and HALT with `pc` held. Without the macro → `pc`+1 and `err_o` = 0.

Source files
------------

// File: rtl/ppwm_pkg.sv
// Shared command encoding and types for the programmable PWM executor.
// Command word: [7:5] command, [4] target, [3:0] argument.
package ppwm_pkg;

  typedef enum logic [2:0] {
    CMD_CTRL   = 3'd0,
    CMD_SET    = 3'd1,
    CMD_ARITH  = 3'd2,
    CMD_SHIFT  = 3'd3,
    CMD_RSRV   = 3'd4,
    CMD_JUMP   = 3'd5,
    CMD_CMP    = 3'd6,
    CMD_BRANCH = 3'd7
  } command_e;

  typedef enum logic {
    TGT_PWM = 1'b0,
    TGT_REG = 1'b1
  } target_e;

  typedef enum logic [1:0] {
    CMP_GCNT_PWM = 2'd0,
    CMP_GCNT_REG = 2'd1,
    CMP_PWM_REG  = 2'd2,
    CMP_NONE     = 2'd3
  } cmp_args_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_WAIT = 2'd2,
    ST_HALT = 2'd3
  } exec_state_e;

  typedef enum logic [1:0] {
    CTRL_NOP     = 2'd0,
    CTRL_HALT    = 2'd1,
    CTRL_WAIT    = 2'd2,
    CTRL_RESTART = 2'd3
  } ctrl_func_e;

  typedef struct packed {
    command_e   cmd;
    target_e    trgt;
    logic [3:0] arg;
  } instr_t;

  localparam logic [7:0] GCNT_MAX = 8'hFF;

  // Unsigned 8-bit operand plus signed 4-bit delta, clamped to 0..255.
  function automatic logic [7:0] sat_add(input logic [7:0] op, input logic [3:0] delta);
    logic [9:0] sum;
    sum = {2'b00, op} + {{6{delta[3]}}, delta};
    if (sum[9]) begin
      return 8'h00;
    end else if (sum[8]) begin
      return 8'hFF;
    end else begin
      return sum[7:0];
    end
  endfunction

endpackage

// File: rtl/ppwm_alu.sv
// Combinational result path for the register-writing commands
// (SET, ARITH with saturation, SHIFT). Other commands pass the operand through.
module ppwm_alu
  import ppwm_pkg::*;
(
  input  command_e   cmd_i,
  input  logic [7:0] operand_i,
  input  logic [3:0] arg_i,
  output logic [7:0] result_o
);

  // Select the new target value for the current command.
  always_comb begin
    result_o = operand_i;
    case (cmd_i)
      CMD_SET:   result_o = {arg_i, 4'h0};
      CMD_ARITH: result_o = sat_add(operand_i, arg_i);
      CMD_SHIFT: result_o = arg_i[3] ? (operand_i >> arg_i[2:0])
                                     : (operand_i << arg_i[2:0]);
      default:   result_o = operand_i;
    endcase
  end

endmodule

// File: rtl/ppwm_exec.sv
// Programmable PWM instruction executor: fetches one command word per cycle
// from an external store at pc_o, updates pwm_val/reg_val/flag, runs the
// free-running period counter and drives the registered PWM output.
// Optional feature: define PPWM_RSRV_TRAP_EN to make the reserved command
// trap (sticky err_o, HALT); otherwise it is a NOP and err_o is tied low.
module ppwm_exec
  import ppwm_pkg::*;
#(
  parameter int PROG_DEPTH = 16
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          ena_i,
  input  logic                          start_i,
  input  logic [7:0]                    instr_i,
  output logic [$clog2(PROG_DEPTH)-1:0] pc_o,
  output logic                          pwm_o,
  output logic                          running_o,
  output logic                          err_o
);

  localparam int PW = $clog2(PROG_DEPTH);

  instr_t      instr;
  exec_state_e state_q;
  logic [PW-1:0] pc_q;
  logic [7:0]  pwm_val_q;
  logic [7:0]  reg_val_q;
  logic [7:0]  gcnt_q;
  logic        flag_q;
  logic        pwm_q;
`ifdef PPWM_RSRV_TRAP_EN
  logic        err_q;
`endif

  logic [7:0]    operand;
  logic [7:0]    alu_result;
  logic [PW-1:0] pc_inc_d;
  logic [PW-1:0] pc_jump_d;
  logic [PW-1:0] jump_off;
  logic [7:0]    cmp_a;
  logic [7:0]    cmp_b;
  logic          cmp_valid;
  logic          flag_d;

  assign instr = instr_t'(instr_i);

  // Sign-extend (or truncate) the 4-bit jump offset to the pc width.
  generate
    if (PW > 4) begin : g_off_ext
      assign jump_off = {{(PW-4){instr.arg[3]}}, instr.arg};
    end else if (PW == 4) begin : g_off_eq
      assign jump_off = instr.arg;
    end else begin : g_off_trunc
      assign jump_off = instr.arg[PW-1:0];
    end
  endgenerate

  // pc candidates; both wrap naturally at PROG_DEPTH.
  always_comb begin
    pc_inc_d  = pc_q + PW'(1);
    pc_jump_d = pc_q + jump_off;
  end

  assign operand = (instr.trgt == TGT_REG) ? reg_val_q : pwm_val_q;

  ppwm_alu u_alu (
    .cmd_i     (instr.cmd),
    .operand_i (operand),
    .arg_i     (instr.arg),
    .result_o  (alu_result)
  );

  // Compare operand selection; selector 11 forces the flag low.
  always_comb begin
    cmp_a     = gcnt_q;
    cmp_b     = pwm_val_q;
    cmp_valid = 1'b1;
    case (cmp_args_e'(instr.arg[1:0]))
      CMP_GCNT_PWM: begin cmp_a = gcnt_q;    cmp_b = pwm_val_q; end
      CMP_GCNT_REG: begin cmp_a = gcnt_q;    cmp_b = reg_val_q; end
      CMP_PWM_REG:  begin cmp_a = pwm_val_q; cmp_b = reg_val_q; end
      default:      cmp_valid = 1'b0;
    endcase
    flag_d = cmp_valid & (instr.arg[2] ? (cmp_a == cmp_b) : (cmp_a < cmp_b));
  end

  // Control FSM and command execution; start_i wins over the fetched command.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= ST_IDLE;
      pc_q      <= '0;
      pwm_val_q <= 8'h00;
      reg_val_q <= 8'h00;
      flag_q    <= 1'b0;
`ifdef PPWM_RSRV_TRAP_EN
      err_q     <= 1'b0;
`endif
    end else if (ena_i) begin
      if (start_i) begin
        state_q <= ST_RUN;
        pc_q    <= '0;
`ifdef PPWM_RSRV_TRAP_EN
        err_q   <= 1'b0;
`endif
      end else begin
        case (state_q)
          ST_RUN: begin
            case (instr.cmd)
              CMD_CTRL: begin
                case (ctrl_func_e'(instr.arg[1:0]))
                  CTRL_NOP:     pc_q    <= pc_inc_d;
                  CTRL_HALT:    state_q <= ST_HALT;
                  CTRL_WAIT:    state_q <= ST_WAIT;
                  CTRL_RESTART: pc_q    <= '0;
                  default:      pc_q    <= pc_inc_d;
                endcase
              end
              CMD_SET, CMD_ARITH, CMD_SHIFT: begin
                if (instr.trgt == TGT_REG) begin
                  reg_val_q <= alu_result;
                end else begin
                  pwm_val_q <= alu_result;
                end
                pc_q <= pc_inc_d;
              end
              CMD_RSRV: begin
`ifdef PPWM_RSRV_TRAP_EN
                err_q   <= 1'b1;
                state_q <= ST_HALT;
`else
                pc_q    <= pc_inc_d;
`endif
              end
              CMD_JUMP:   pc_q <= pc_jump_d;
              CMD_CMP: begin
                flag_q <= flag_d;
                pc_q   <= pc_inc_d;
              end
              CMD_BRANCH: pc_q <= flag_q ? pc_jump_d : pc_inc_d;
              default:    pc_q <= pc_inc_d;
            endcase
          end
          ST_WAIT: begin
            if (gcnt_q == GCNT_MAX) begin
              state_q <= ST_RUN;
              pc_q    <= pc_inc_d;
            end
          end
          default: ;
        endcase
      end
    end
  end

  // Free-running period counter and registered PWM compare.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      gcnt_q <= 8'h00;
      pwm_q  <= 1'b0;
    end else if (ena_i) begin
      gcnt_q <= gcnt_q + 8'd1;
      pwm_q  <= (gcnt_q < pwm_val_q);
    end
  end

  assign pc_o      = pc_q;
  assign pwm_o     = pwm_q;
  assign running_o = (state_q == ST_RUN) || (state_q == ST_WAIT);
`ifdef PPWM_RSRV_TRAP_EN
  assign err_o     = err_q;
`else
  assign err_o     = 1'b0;
`endif

endmodule

// File: tb/tb_ppwm_exec.sv
// Self-checking bench for ppwm_exec: small programs are loaded into a local
// program store, expected per-cycle snapshots are queued, then popped and
// compared as the executor steps.
module tb_ppwm_exec;
  import ppwm_pkg::*;

  logic       clk = 1'b0;
  logic       rst_ni = 1'b0;
  logic       ena_i = 1'b0;
  logic       start_i = 1'b0;
  logic [7:0] instr_i;
  logic [3:0] pc_o;
  logic       pwm_o;
  logic       running_o;
  logic       err_o;

  logic [7:0] prog [16];
  assign instr_i = prog[pc_o];

  ppwm_exec #(.PROG_DEPTH(16)) dut (
    .clk_i     (clk),
    .rst_ni    (rst_ni),
    .ena_i     (ena_i),
    .start_i   (start_i),
    .instr_i   (instr_i),
    .pc_o      (pc_o),
    .pwm_o     (pwm_o),
    .running_o (running_o),
    .err_o     (err_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] pc;
    logic [7:0] pwm;
    logic [7:0] rg;
    logic       flag;
    logic       run;
    logic       err;
  } snap_t;

  snap_t      exp_q[$];
  int         checks = 0;
  int         failures = 0;
  logic [7:0] gcnt_m = 8'd0;

  function automatic logic [7:0] mk(input logic [2:0] cmd, input logic t, input logic [3:0] arg);
    return {cmd, t, arg};
  endfunction

  function automatic snap_t sn(input int pc, input int pwm, input int rg,
                               input int flag, input int run, input int err);
    snap_t s;
    s.pc = 4'(pc); s.pwm = 8'(pwm); s.rg = 8'(rg);
    s.flag = 1'(flag); s.run = 1'(run); s.err = 1'(err);
    return s;
  endfunction

  function automatic snap_t observe();
    return {pc_o, dut.pwm_val_q, dut.reg_val_q, dut.flag_q, running_o, err_o};
  endfunction

  function automatic string fmt(input snap_t s);
    return $sformatf("pc=%0d pwm=%0d reg=%0d flag=%0b run=%0b err=%0b",
                     s.pc, s.pwm, s.rg, s.flag, s.run, s.err);
  endfunction

  task automatic tick();
    logic en;
    en = ena_i & rst_ni;
    @(posedge clk);
    if (en) gcnt_m = gcnt_m + 8'd1;
    #1;
  endtask

  task automatic clear_prog();
    for (int i = 0; i < 16; i++) prog[i] = mk(CMD_CTRL, TGT_PWM, 4'd0);
  endtask

  task automatic test_reset();
    snap_t e, o;
    int highs;
    clear_prog();
    rst_ni = 1'b0; ena_i = 1'b0; gcnt_m = 8'd0;
    tick(); tick();
    exp_q.push_back(sn(0, 0, 0, 0, 0, 0));
    e = exp_q.pop_front(); o = observe(); checks++;
    if (o !== e) begin failures++; $display("FAIL reset_state got %s expected %s", fmt(o), fmt(e)); end
    else $display("ok reset_state %s", fmt(o));
    rst_ni = 1'b1; ena_i = 1'b1;
    highs = 0;
    for (int i = 0; i < 20; i++) begin tick(); highs += int'(pwm_o); end
    exp_q.push_back(sn(0, 0, 0, 0, 0, 0));
    e = exp_q.pop_front(); o = observe(); checks++;
    if (o !== e) begin failures++; $display("FAIL idle_state got %s expected %s", fmt(o), fmt(e)); end
    else $display("ok idle_state %s", fmt(o));
    checks++;
    if (dut.gcnt_q !== gcnt_m) begin failures++; $display("FAIL idle_gcnt got %0d expected %0d", dut.gcnt_q, gcnt_m); end
    else $display("ok idle_gcnt %0d", dut.gcnt_q);
    checks++;
    if (highs !== 0) begin failures++; $display("FAIL idle_pwm_highs got %0d expected 0", highs); end
    else $display("ok idle_pwm_highs %0d", highs);
  endtask

  task automatic test_set_wait_loop();
    snap_t e, o;
    int highs;
    clear_prog();
    prog[0] = mk(CMD_SET, TGT_PWM, 4'd8);
    prog[1] = mk(CMD_CTRL, TGT_PWM, 4'd2);
    prog[2] = mk(CMD_JUMP, TGT_PWM, 4'hE);
    exp_q.push_back(sn(0, 0, 0, 0, 1, 0));
    exp_q.push_back(sn(1, 128, 0, 0, 1, 0));
    exp_q.push_back(sn(1, 128, 0, 0, 1, 0));
    start_i = 1'b1;
    for (int i = 0; exp_q.size() > 0; i++) begin
      tick(); start_i = 1'b0;
      e = exp_q.pop_front(); o = observe(); checks++;
      if (o !== e) begin failures++; $display("FAIL wait_entry[%0d] got %s expected %s", i, fmt(o), fmt(e)); end
      else $display("ok wait_entry[%0d] %s", i, fmt(o));
    end
    for (int i = 0; i < 300; i++) tick();
    for (int i = 0; i < 256 && gcnt_m != 8'hFF; i++) tick();
    exp_q.push_back(sn(2, 128, 0, 0, 1, 0));
    exp_q.push_back(sn(0, 128, 0, 0, 1, 0));
    exp_q.push_back(sn(1, 128, 0, 0, 1, 0));
    exp_q.push_back(sn(1, 128, 0, 0, 1, 0));
    for (int i = 0; exp_q.size() > 0; i++) begin
      tick();
      e = exp_q.pop_front(); o = observe(); checks++;
      if (o !== e) begin failures++; $display("FAIL wait_exit[%0d] got %s expected %s", i, fmt(o), fmt(e)); end
      else $display("ok wait_exit[%0d] %s", i, fmt(o));
    end
    highs = 0;
    for (int i = 0; i < 256; i++) begin tick(); highs += int'(pwm_o); end
    checks++;
    if (highs !== 128) begin failures++; $display("FAIL pwm_duty got %0d expected 128", highs); end
    else $display("ok pwm_duty %0d", highs);
    for (int i = 0; i < 256 && gcnt_m != 8'd128; i++) tick();
    checks++;
    if (pwm_o !== 1'b1) begin failures++; $display("FAIL pwm_phase_hi got %0b expected 1", pwm_o); end
    else $display("ok pwm_phase_hi %0b", pwm_o);
    tick();
    checks++;
    if (pwm_o !== 1'b0) begin failures++; $display("FAIL pwm_phase_lo got %0b expected 0", pwm_o); end
    else $display("ok pwm_phase_lo %0b", pwm_o);
  endtask

  task automatic test_arith_sat();
    snap_t e, o;
    clear_prog();
    prog[0] = mk(CMD_SET,   TGT_REG, 4'd0);
    prog[1] = mk(CMD_ARITH, TGT_REG, 4'hF);
    prog[2] = mk(CMD_CTRL,  TGT_PWM, 4'd1);
    exp_q.push_back(sn(0, 128, 0, 0, 1, 0));
    exp_q.push_back(sn(1, 128, 0, 0, 1, 0));
    exp_q.push_back(sn(2, 128, 0, 0, 1, 0));
    exp_q.push_back(sn(2, 128, 0, 0, 0, 0));
    exp_q.push_back(sn(2, 128, 0, 0, 0, 0));
    start_i = 1'b1;
    for (int i = 0; exp_q.size() > 0; i++) begin
      tick(); start_i = 1'b0;
      e = exp_q.pop_front(); o = observe(); checks++;
      if (o !== e) begin failures++; $display("FAIL arith_low[%0d] got %s expected %s", i, fmt(o), fmt(e)); end
      else $display("ok arith_low[%0d] %s", i, fmt(o));
    end
    clear_prog();
    prog[0] = mk(CMD_SET, TGT_REG, 4'd15);
    for (int i = 1; i <= 3; i++) prog[i] = mk(CMD_ARITH, TGT_REG, 4'd7);
    prog[4] = mk(CMD_CTRL, TGT_PWM, 4'd1);
    exp_q.push_back(sn(0, 128, 0, 0, 1, 0));
    exp_q.push_back(sn(1, 128, 240, 0, 1, 0));
    exp_q.push_back(sn(2, 128, 247, 0, 1, 0));
    exp_q.push_back(sn(3, 128, 254, 0, 1, 0));
    exp_q.push_back(sn(4, 128, 255, 0, 1, 0));
    exp_q.push_back(sn(4, 128, 255, 0, 0, 0));
    start_i = 1'b1;
    for (int i = 0; exp_q.size() > 0; i++) begin
      tick(); start_i = 1'b0;
      e = exp_q.pop_front(); o = observe(); checks++;
      if (o !== e) begin failures++; $display("FAIL arith_high[%0d] got %s expected %s", i, fmt(o), fmt(e)); end
      else $display("ok arith_high[%0d] %s", i, fmt(o));
    end
  endtask

  task automatic test_shift_cmp_branch();
    snap_t e, o;
    clear_prog();
    prog[0]  = mk(CMD_SET,    TGT_PWM, 4'd1);
    prog[1]  = mk(CMD_SHIFT,  TGT_PWM, 4'hC);
    prog[2]  = mk(CMD_SET,    TGT_REG, 4'd0);
    prog[3]  = mk(CMD_ARITH,  TGT_REG, 4'd1);
    prog[4]  = mk(CMD_CMP,    TGT_PWM, 4'd6);
    prog[5]  = mk(CMD_BRANCH, TGT_PWM, 4'd3);
    prog[6]  = mk(CMD_CTRL,   TGT_PWM, 4'd1);
    prog[7]  = mk(CMD_CTRL,   TGT_PWM, 4'd1);
    prog[8]  = mk(CMD_SHIFT,  TGT_REG, 4'd3);
    prog[9]  = mk(CMD_CMP,    TGT_PWM, 4'd3);
    prog[10] = mk(CMD_BRANCH, TGT_PWM, 4'd3);
    prog[11] = mk(CMD_CMP,    TGT_PWM, 4'd2);
    prog[12] = mk(CMD_BRANCH, TGT_PWM, 4'hA);
    exp_q.push_back(sn(0, 128, 255, 0, 1, 0));
    exp_q.push_back(sn(1, 16, 255, 0, 1, 0));
    exp_q.push_back(sn(2, 1, 255, 0, 1, 0));
    exp_q.push_back(sn(3, 1, 0, 0, 1, 0));
    exp_q.push_back(sn(4, 1, 1, 0, 1, 0));
    exp_q.push_back(sn(5, 1, 1, 1, 1, 0));
    exp_q.push_back(sn(8, 1, 1, 1, 1, 0));
    exp_q.push_back(sn(9, 1, 8, 1, 1, 0));
    exp_q.push_back(sn(10, 1, 8, 0, 1, 0));
    exp_q.push_back(sn(11, 1, 8, 0, 1, 0));
    exp_q.push_back(sn(12, 1, 8, 1, 1, 0));
    exp_q.push_back(sn(6, 1, 8, 1, 1, 0));
    exp_q.push_back(sn(6, 1, 8, 1, 0, 0));
    start_i = 1'b1;
    for (int i = 0; exp_q.size() > 0; i++) begin
      tick(); start_i = 1'b0;
      e = exp_q.pop_front(); o = observe(); checks++;
      if (o !== e) begin failures++; $display("FAIL shift_cmp_br[%0d] got %s expected %s", i, fmt(o), fmt(e)); end
      else $display("ok shift_cmp_br[%0d] %s", i, fmt(o));
    end
  endtask

  task automatic test_jump_wrap_start();
    snap_t e, o;
    clear_prog();
    prog[0]  = mk(CMD_JUMP, TGT_REG, 4'hF);
    prog[15] = mk(CMD_CTRL, TGT_PWM, 4'd1);
    exp_q.push_back(sn(0, 1, 8, 1, 1, 0));
    exp_q.push_back(sn(15, 1, 8, 1, 1, 0));
    exp_q.push_back(sn(15, 1, 8, 1, 0, 0));
    start_i = 1'b1;
    for (int i = 0; exp_q.size() > 0; i++) begin
      tick(); start_i = 1'b0;
      e = exp_q.pop_front(); o = observe(); checks++;
      if (o !== e) begin failures++; $display("FAIL jump_wrap[%0d] got %s expected %s", i, fmt(o), fmt(e)); end
      else $display("ok jump_wrap[%0d] %s", i, fmt(o));
    end
    clear_prog();
    prog[0] = mk(CMD_SET,   TGT_REG, 4'd2);
    prog[1] = mk(CMD_ARITH, TGT_REG, 4'd5);
    prog[2] = mk(CMD_CTRL,  TGT_PWM, 4'd1);
    exp_q.push_back(sn(0, 1, 8, 1, 1, 0));
    exp_q.push_back(sn(1, 1, 32, 1, 1, 0));
    start_i = 1'b1;
    for (int i = 0; exp_q.size() > 0; i++) begin
      tick(); start_i = 1'b0;
      e = exp_q.pop_front(); o = observe(); checks++;
      if (o !== e) begin failures++; $display("FAIL start_pre[%0d] got %s expected %s", i, fmt(o), fmt(e)); end
      else $display("ok start_pre[%0d] %s", i, fmt(o));
    end
    exp_q.push_back(sn(0, 1, 32, 1, 1, 0));
    exp_q.push_back(sn(1, 1, 32, 1, 1, 0));
    exp_q.push_back(sn(2, 1, 37, 1, 1, 0));
    exp_q.push_back(sn(2, 1, 37, 1, 0, 0));
    start_i = 1'b1;
    for (int i = 0; exp_q.size() > 0; i++) begin
      tick(); start_i = 1'b0;
      e = exp_q.pop_front(); o = observe(); checks++;
      if (o !== e) begin failures++; $display("FAIL start_override[%0d] got %s expected %s", i, fmt(o), fmt(e)); end
      else $display("ok start_override[%0d] %s", i, fmt(o));
    end
  endtask

  task automatic test_ena_freeze();
    snap_t e, o;
    logic [7:0] g_frozen;
    clear_prog();
    prog[1] = mk(CMD_JUMP, TGT_PWM, 4'hF);
    exp_q.push_back(sn(0, 1, 37, 1, 1, 0));
    exp_q.push_back(sn(1, 1, 37, 1, 1, 0));
    exp_q.push_back(sn(0, 1, 37, 1, 1, 0));
    exp_q.push_back(sn(1, 1, 37, 1, 1, 0));
    start_i = 1'b1;
    for (int i = 0; exp_q.size() > 0; i++) begin
      tick(); start_i = 1'b0;
      e = exp_q.pop_front(); o = observe(); checks++;
      if (o !== e) begin failures++; $display("FAIL ena_loop[%0d] got %s expected %s", i, fmt(o), fmt(e)); end
      else $display("ok ena_loop[%0d] %s", i, fmt(o));
    end
    g_frozen = gcnt_m;
    ena_i = 1'b0; start_i = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    exp_q.push_back(sn(1, 1, 37, 1, 1, 0));
    e = exp_q.pop_front(); o = observe(); checks++;
    if (o !== e) begin failures++; $display("FAIL ena_frozen got %s expected %s", fmt(o), fmt(e)); end
    else $display("ok ena_frozen %s", fmt(o));
    checks++;
    if (dut.gcnt_q !== g_frozen) begin failures++; $display("FAIL ena_gcnt got %0d expected %0d", dut.gcnt_q, g_frozen); end
    else $display("ok ena_gcnt %0d", dut.gcnt_q);
    start_i = 1'b0; ena_i = 1'b1;
    tick();
    exp_q.push_back(sn(0, 1, 37, 1, 1, 0));
    e = exp_q.pop_front(); o = observe(); checks++;
    if (o !== e) begin failures++; $display("FAIL ena_resume got %s expected %s", fmt(o), fmt(e)); end
    else $display("ok ena_resume %s", fmt(o));
    checks++;
    if (dut.gcnt_q !== gcnt_m) begin failures++; $display("FAIL ena_gcnt_resume got %0d expected %0d", dut.gcnt_q, gcnt_m); end
    else $display("ok ena_gcnt_resume %0d", dut.gcnt_q);
  endtask

  task automatic test_rsrv();
    snap_t e, o;
    clear_prog();
    prog[1] = mk(CMD_RSRV, TGT_PWM, 4'd0);
    prog[2] = mk(CMD_CTRL, TGT_PWM, 4'd1);
    exp_q.push_back(sn(0, 1, 37, 1, 1, 0));
    exp_q.push_back(sn(1, 1, 37, 1, 1, 0));
`ifdef PPWM_RSRV_TRAP_EN
    exp_q.push_back(sn(1, 1, 37, 1, 0, 1));
    exp_q.push_back(sn(1, 1, 37, 1, 0, 1));
`else
    exp_q.push_back(sn(2, 1, 37, 1, 1, 0));
    exp_q.push_back(sn(2, 1, 37, 1, 0, 0));
`endif
    start_i = 1'b1;
    for (int i = 0; exp_q.size() > 0; i++) begin
      tick(); start_i = 1'b0;
      e = exp_q.pop_front(); o = observe(); checks++;
      if (o !== e) begin failures++; $display("FAIL rsrv[%0d] got %s expected %s", i, fmt(o), fmt(e)); end
      else $display("ok rsrv[%0d] %s", i, fmt(o));
    end
    exp_q.push_back(sn(0, 1, 37, 1, 1, 0));
    exp_q.push_back(sn(1, 1, 37, 1, 1, 0));
    start_i = 1'b1;
    for (int i = 0; exp_q.size() > 0; i++) begin
      tick(); start_i = 1'b0;
      e = exp_q.pop_front(); o = observe(); checks++;
      if (o !== e) begin failures++; $display("FAIL rsrv_restart[%0d] got %s expected %s", i, fmt(o), fmt(e)); end
      else $display("ok rsrv_restart[%0d] %s", i, fmt(o));
    end
  endtask

  task automatic test_reset_mid();
    snap_t e, o;
    #3;
    rst_ni = 1'b0;
    gcnt_m = 8'd0;
    #1;
    exp_q.push_back(sn(0, 0, 0, 0, 0, 0));
    e = exp_q.pop_front(); o = observe(); checks++;
    if (o !== e) begin failures++; $display("FAIL async_reset got %s expected %s", fmt(o), fmt(e)); end
    else $display("ok async_reset %s", fmt(o));
    checks++;
    if ({dut.gcnt_q, pwm_o} !== 9'd0) begin
      failures++; $display("FAIL async_reset_cnt got gcnt=%0d pwm=%0b expected 0/0", dut.gcnt_q, pwm_o);
    end else $display("ok async_reset_cnt gcnt=%0d pwm=%0b", dut.gcnt_q, pwm_o);
    tick();
    rst_ni = 1'b1;
  endtask

  initial begin
    test_reset();
    test_set_wait_loop();
    test_arith_sat();
    test_shift_cmp_branch();
    test_jump_wrap_start();
    test_ena_freeze();
    test_rsrv();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
